// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item, multi-coin vending controller.
// Takes four coin denominations and sells NUM_ITEMS products at one common
// price. Each slot has its own stock counter. Change is paid out greedily,
// one coin per cycle. Every output is registered: the next-cycle value of
// each output is decoded from the next state and the next credit, so the
// outputs behave as Moore outputs of the state/credit registers.
module vending_machine_multi #(
    parameter int PRICE      = 15,
    parameter int CREDIT_W   = 8,
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_in,
    input  logic [1:0]                   coin_code,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel,
    input  logic                         dispense,
    input  logic                         cancel,
    output logic                         Item_out,
    output logic [$clog2(NUM_ITEMS)-1:0] item_id,
    output logic                         change_valid,
    output logic [1:0]                   change_code,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         ready,
    output logic [NUM_ITEMS-1:0]         sold_out,
    output logic                         coin_reject,
    output logic                         sold_out_err
);

    localparam int SEL_W = $clog2(NUM_ITEMS);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    // Credit value of a coin code. Coin acceptor and change hopper share this encoding.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    coin_value = CREDIT_W'(1);
            2'd1:    coin_value = CREDIT_W'(2);
            2'd2:    coin_value = CREDIT_W'(5);
            default: coin_value = CREDIT_W'(10);
        endcase
    endfunction

    // Greedy choice of change coin: the largest denomination that still fits in the credit.
    function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(10))     greedy_code = 2'd3;
        else if (c >= CREDIT_W'(5)) greedy_code = 2'd2;
        else if (c >= CREDIT_W'(2)) greedy_code = 2'd1;
        else                        greedy_code = 2'd0;
    endfunction

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [STOCK_W-1:0]    stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]    stock_d [NUM_ITEMS];
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  item_out_q, item_out_d;
    logic [SEL_W-1:0]      item_id_q, item_id_d;
    logic                  change_valid_q, change_valid_d;
    logic [1:0]            change_code_q, change_code_d;
    logic                  ready_q, ready_d;
    logic [NUM_ITEMS-1:0]  sold_out_q, sold_out_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  sold_out_err_q, sold_out_err_d;

    logic                  take_coin;
    logic [CREDIT_W:0]     coin_sum;

    // Next-state, credit and stock update. Inside COLLECT, cancel wins over dispense, which wins over a coin.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        sel_d          = sel_q;
        coin_reject_d  = 1'b0;
        sold_out_err_d = 1'b0;
        take_coin      = 1'b0;
        coin_sum       = {1'b0, credit_q} + {1'b0, coin_value(coin_code)};

        case (state_q)
            IDLE: begin
                if (coin_in) begin
                    credit_d = coin_value(coin_code);
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_d       = REFUND;
                    coin_reject_d = coin_in;
                end else if (dispense && (credit_q >= PRICE_C)) begin
                    if (stock_q[sel] != '0) begin
                        sel_d         = sel;
                        state_d       = VEND;
                        coin_reject_d = coin_in;
                    end else begin
                        // A refused purchase does not block a coin that arrives in the same cycle.
                        sold_out_err_d = 1'b1;
                        take_coin      = coin_in;
                    end
                end else begin
                    take_coin = coin_in;
                end
                if (take_coin) begin
                    if (coin_sum <= CREDIT_MAX) credit_d = coin_sum[CREDIT_W-1:0];
                    else                        coin_reject_d = 1'b1;
                end
            end
            VEND: begin
                coin_reject_d = coin_in;
                if (stock_q[sel_q] != '0) stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_d != '0) ? REFUND : IDLE;
            end
            REFUND: begin
                coin_reject_d = coin_in;
                if (credit_q != '0) credit_d = credit_q - coin_value(greedy_code(credit_q));
                if (credit_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next-cycle output decode, taken from the next state and the next credit.
    always_comb begin
        item_out_d     = (state_d == VEND);
        item_id_d      = (state_d == VEND) ? sel_d : '0;
        change_valid_d = (state_d == REFUND) && (credit_d != '0);
        change_code_d  = change_valid_d ? greedy_code(credit_d) : 2'd0;
        ready_d        = (state_d == COLLECT) && (credit_d >= PRICE_C);
    end

    // sold_out_d bit gi is set while slot gi has no stock left.
    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_sold_out
            assign sold_out_d[gi] = (stock_d[gi] == '0);
        end
    endgenerate

    // State, credit, stock and registered outputs. Reset reloads the stock and drops any pending credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
            sel_q          <= '0;
            item_out_q     <= 1'b0;
            item_id_q      <= '0;
            change_valid_q <= 1'b0;
            change_code_q  <= 2'd0;
            ready_q        <= 1'b0;
            sold_out_q     <= {NUM_ITEMS{STOCK_INIT == 0}};
            coin_reject_q  <= 1'b0;
            sold_out_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            sel_q          <= sel_d;
            item_out_q     <= item_out_d;
            item_id_q      <= item_id_d;
            change_valid_q <= change_valid_d;
            change_code_q  <= change_code_d;
            ready_q        <= ready_d;
            sold_out_q     <= sold_out_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_err_q <= sold_out_err_d;
        end
    end

    assign Item_out     = item_out_q;
    assign item_id      = item_id_q;
    assign change_valid = change_valid_q;
    assign change_code  = change_code_q;
    assign credit       = credit_q;
    assign ready        = ready_q;
    assign sold_out     = sold_out_q;
    assign coin_reject  = coin_reject_q;
    assign sold_out_err = sold_out_err_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Testbench for vending_machine_multi (default parameters: PRICE 15, 4 slots of 3 items).
// A scoreboard queue holds the expected dispense and change events. The
// scenario tasks fill it as they drive stimulus, and a negedge monitor
// empties it as the DUT produces those events.
module tb_vending_machine_multi;

    logic       clk;
    logic       rst;
    logic       coin_in;
    logic [1:0] coin_code;
    logic [1:0] sel;
    logic       dispense;
    logic       cancel;
    logic       Item_out;
    logic [1:0] item_id;
    logic       change_valid;
    logic [1:0] change_code;
    logic [7:0] credit;
    logic       ready;
    logic [3:0] sold_out;
    logic       coin_reject;
    logic       sold_out_err;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entry: bit 2 = item event (1) or change event (0); bits 1:0 = item_id or change_code.
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    logic [2:0] mon_obs;

    vending_machine_multi #(
        .PRICE(15), .CREDIT_W(8), .NUM_ITEMS(4), .STOCK_W(4), .STOCK_INIT(3)
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .coin_code(coin_code), .sel(sel),
        .dispense(dispense), .cancel(cancel), .Item_out(Item_out), .item_id(item_id),
        .change_valid(change_valid), .change_code(change_code), .credit(credit),
        .ready(ready), .sold_out(sold_out), .coin_reject(coin_reject),
        .sold_out_err(sold_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every dispense or change event must match the next scoreboard entry.
    always @(negedge clk) begin
        if (Item_out === 1'b1 || change_valid === 1'b1) begin
            n_cmp++;
            mon_obs = {Item_out, (Item_out ? item_id : change_code)};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL monitor_unexpected: got event %b, scoreboard empty", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    n_err++;
                    $display("FAIL monitor_event: got %b expected %b", mon_obs, mon_exp);
                end else begin
                    $display("txn %s %0d", Item_out ? "item" : "change", mon_obs[1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_in   = 1'b1;
        coin_code = c;
        tick();
        coin_in   = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (!(credit == 8'd0 && change_valid == 1'b0) && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!(credit == 8'd0 && change_valid == 1'b0)) begin
            n_err++;
            $display("FAIL %s_timeout: credit=%0d change_valid=%0b after %0d cycles, required 0/0", name, credit, change_valid, budget);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_queue: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({credit, ready, Item_out, change_valid, coin_reject, sold_out_err, sold_out} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: credit=%0d ready=%0b item=%0b cv=%0b rej=%0b soe=%0b so=%b, required all 0",
                     credit, ready, Item_out, change_valid, coin_reject, sold_out_err, sold_out);
        end
        // A dispense request in IDLE does nothing.
        dispense = 1'b1; sel = 2'd0;
        tick();
        dispense = 1'b0;
        n_cmp++;
        if (sold_out_err !== 1'b0 || Item_out !== 1'b0 || credit !== 8'd0) begin
            n_err++;
            $display("FAIL idle_dispense: soe=%0b item=%0b credit=%0d, required 0/0/0", sold_out_err, Item_out, credit);
        end
    endtask

    task automatic test_exact_price();
        coin(2'd3);
        coin(2'd2);
        n_cmp++;
        if (credit !== 8'd15 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL exact_credit: credit=%0d ready=%0b, required 15/1", credit, ready);
        end
        exp_q.push_back({1'b1, 2'd2});
        dispense = 1'b1; sel = 2'd2;
        tick();
        dispense = 1'b0;
        n_cmp++;
        if (Item_out !== 1'b1 || item_id !== 2'd2) begin
            n_err++;
            $display("FAIL exact_vend: item=%0b id=%0d, required 1/2", Item_out, item_id);
        end
        tick();
        n_cmp++;
        if (Item_out !== 1'b0 || item_id !== 2'd0 || credit !== 8'd0 || change_valid !== 1'b0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL exact_after: item=%0b id=%0d credit=%0d cv=%0b ready=%0b, required 0/0/0/0/0",
                     Item_out, item_id, credit, change_valid, ready);
        end
        drain("exact", 4);
    endtask

    task automatic test_change();
        coin(2'd3);
        coin(2'd3);
        exp_q.push_back({1'b1, 2'd0});
        exp_q.push_back({1'b0, 2'd2});
        dispense = 1'b1; sel = 2'd0;
        tick();
        dispense = 1'b0;
        n_cmp++;
        if (Item_out !== 1'b1 || item_id !== 2'd0) begin
            n_err++;
            $display("FAIL change_vend: item=%0b id=%0d, required 1/0", Item_out, item_id);
        end
        // A coin offered while vending is refused.
        coin(2'd0);
        n_cmp++;
        if (change_valid !== 1'b1 || change_code !== 2'd2 || credit !== 8'd5 || coin_reject !== 1'b1 || Item_out !== 1'b0) begin
            n_err++;
            $display("FAIL change_coin: cv=%0b code=%0d credit=%0d rej=%0b item=%0b, required 1/2/5/1/0",
                     change_valid, change_code, credit, coin_reject, Item_out);
        end
        tick();
        n_cmp++;
        if (change_valid !== 1'b0 || credit !== 8'd0 || coin_reject !== 1'b0) begin
            n_err++;
            $display("FAIL change_done: cv=%0b credit=%0d rej=%0b, required 0/0/0", change_valid, credit, coin_reject);
        end
        drain("change", 4);
    endtask

    task automatic test_cancel();
        logic [1:0] codes [3];
        logic [7:0] creds [3];
        codes[0] = 2'd3; codes[1] = 2'd1; codes[2] = 2'd0;
        creds[0] = 8'd13; creds[1] = 8'd3; creds[2] = 8'd1;
        coin(2'd1); coin(2'd1); coin(2'd0);
        exp_q.push_back({1'b0, 2'd2});
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_cmp++;
        if (change_valid !== 1'b1 || change_code !== 2'd2 || credit !== 8'd5) begin
            n_err++;
            $display("FAIL cancel5: cv=%0b code=%0d credit=%0d, required 1/2/5", change_valid, change_code, credit);
        end
        tick();
        n_cmp++;
        if (change_valid !== 1'b0 || credit !== 8'd0) begin
            n_err++;
            $display("FAIL cancel5_done: cv=%0b credit=%0d, required 0/0", change_valid, credit);
        end
        coin(2'd3); coin(2'd1); coin(2'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, codes[i]});
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (change_valid !== 1'b1 || change_code !== codes[i] || credit !== creds[i]) begin
                n_err++;
                $display("FAIL cancel13_coin%0d: cv=%0b code=%0d credit=%0d, required 1/%0d/%0d",
                         i, change_valid, change_code, credit, codes[i], creds[i]);
            end
            tick();
        end
        n_cmp++;
        if (change_valid !== 1'b0 || credit !== 8'd0) begin
            n_err++;
            $display("FAIL cancel13_done: cv=%0b credit=%0d, required 0/0", change_valid, credit);
        end
        drain("cancel", 4);
    endtask

    task automatic test_sold_out();
        for (int b = 0; b < 3; b++) begin
            coin(2'd3); coin(2'd2);
            exp_q.push_back({1'b1, 2'd1});
            dispense = 1'b1; sel = 2'd1;
            tick();
            dispense = 1'b0;
            tick();
        end
        n_cmp++;
        if (sold_out !== 4'b0010) begin
            n_err++;
            $display("FAIL soldout_flags: sold_out=%b, required 0010", sold_out);
        end
        coin(2'd3); coin(2'd2);
        dispense = 1'b1; sel = 2'd1;
        tick();
        dispense = 1'b0;
        n_cmp++;
        if (sold_out_err !== 1'b1 || Item_out !== 1'b0 || credit !== 8'd15 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL soldout_err: soe=%0b item=%0b credit=%0d ready=%0b, required 1/0/15/1",
                     sold_out_err, Item_out, credit, ready);
        end
        tick();
        n_cmp++;
        if (sold_out_err !== 1'b0 || credit !== 8'd15) begin
            n_err++;
            $display("FAIL soldout_pulse: soe=%0b credit=%0d, required 0/15", sold_out_err, credit);
        end
        exp_q.push_back({1'b0, 2'd3});
        exp_q.push_back({1'b0, 2'd2});
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        drain("soldout", 8);
    endtask

    task automatic test_overflow_priority();
        for (int i = 0; i < 25; i++) coin(2'd3);
        n_cmp++;
        if (credit !== 8'd250 || coin_reject !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_fill: credit=%0d rej=%0b, required 250/0", credit, coin_reject);
        end
        coin(2'd3);
        n_cmp++;
        if (credit !== 8'd250 || coin_reject !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_reject: credit=%0d rej=%0b, required 250/1", credit, coin_reject);
        end
        for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, 2'd3});
        cancel = 1'b1; dispense = 1'b1; sel = 2'd0; coin_in = 1'b1; coin_code = 2'd0;
        tick();
        cancel = 1'b0; dispense = 1'b0; coin_in = 1'b0;
        n_cmp++;
        if (coin_reject !== 1'b1 || Item_out !== 1'b0 || change_valid !== 1'b1 || credit !== 8'd250 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL priority: rej=%0b item=%0b cv=%0b credit=%0d ready=%0b, required 1/0/1/250/0",
                     coin_reject, Item_out, change_valid, credit, ready);
        end
        drain("priority", 40);
    endtask

    task automatic test_reset_mid_refund();
        coin(2'd3); coin(2'd3); coin(2'd2);
        exp_q.push_back({1'b0, 2'd3});
        exp_q.push_back({1'b0, 2'd3});
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        n_cmp++;
        if (change_valid !== 1'b1 || credit !== 8'd15) begin
            n_err++;
            $display("FAIL midrefund_pre: cv=%0b credit=%0d, required 1/15", change_valid, credit);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (credit !== 8'd0 || change_valid !== 1'b0 || sold_out !== 4'b0000 || ready !== 1'b0 || Item_out !== 1'b0) begin
            n_err++;
            $display("FAIL midrefund_reset: credit=%0d cv=%0b so=%b ready=%0b item=%0b, required 0/0/0000/0/0",
                     credit, change_valid, sold_out, ready, Item_out);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midrefund_queue: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        // Slot 1 was empty before the reset; it must sell again.
        coin(2'd3); coin(2'd2);
        exp_q.push_back({1'b1, 2'd1});
        dispense = 1'b1; sel = 2'd1;
        tick();
        dispense = 1'b0;
        n_cmp++;
        if (Item_out !== 1'b1 || item_id !== 2'd1) begin
            n_err++;
            $display("FAIL restock_vend: item=%0b id=%0d, required 1/1", Item_out, item_id);
        end
        tick();
        drain("restock", 4);
    endtask

    initial begin
        rst = 1'b1; coin_in = 1'b0; coin_code = 2'd0; sel = 2'd0; dispense = 1'b0; cancel = 1'b0;
        tick();
        tick();
        test_reset();
        test_exact_price();
        test_change();
        test_cancel();
        test_sold_out();
        test_overflow_priority();
        test_reset_mid_refund();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
